// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port program/data memory arbiter.
package mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    // One-hot grant to port id; an empty grant maps to port 0.
    function automatic port_id_t grant_to_id(input logic [NUM_PORTS-1:0] grant);
        return grant[1] ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory side signals of mem_arbiter, bundled with master/slave views.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic [AW-1:0]   p0_addr;
    logic [DW-1:0]   p0_wdata;
    logic [DW/8-1:0] p0_wstrb;
    logic            p0_rstrb;
    logic            p0_gnt;
    logic            p0_done;

    logic [AW-1:0]   p1_addr;
    logic [DW-1:0]   p1_wdata;
    logic [DW/8-1:0] p1_wstrb;
    logic            p1_rstrb;
    logic            p1_gnt;
    logic            p1_done;

    logic [DW-1:0]   rdata;
    logic            busy;

    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic            mem_rstrb;
    logic [DW-1:0]   mem_rdata;

    // Arbiter side: takes requests and memory read data, drives everything else.
    modport slave (
        input  p0_addr, p0_wdata, p0_wstrb, p0_rstrb,
        input  p1_addr, p1_wdata, p1_wstrb, p1_rstrb,
        input  mem_rdata,
        output p0_gnt, p0_done, p1_gnt, p1_done,
        output rdata, busy,
        output mem_addr, mem_wdata, mem_wstrb, mem_rstrb
    );

    modport master (
        output p0_addr, p0_wdata, p0_wstrb, p0_rstrb,
        output p1_addr, p1_wdata, p1_wstrb, p1_rstrb,
        output mem_rdata,
        input  p0_gnt, p0_done, p1_gnt, p1_done,
        input  rdata, busy,
        input  mem_addr, mem_wdata, mem_wstrb, mem_rstrb
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way grant picker: round-robin on ties, or fixed port-0 priority when
// MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] pending,
    input  port_id_t             last,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        grant = '0;
        if (pending[0]) begin
            grant = 2'b01;
        end else if (pending[1]) begin
            grant = 2'b10;
        end
    end
`else
    // On a tie the port that did not win last time goes next.
    always_comb begin
        grant = '0;
        case (pending)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == PORT0) ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between two masters, one transaction at a time (IDLE -> ISSUE -> RESP).
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);

    localparam int SW = DW / 8;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            rd_q, rd_d;
    port_id_t        port_q, port_d;

    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] grant;
    port_id_t             last_ptr;

    assign pending = {bus.p1_rstrb | (|bus.p1_wstrb),
                      bus.p0_rstrb | (|bus.p0_wstrb)};

    rr_pick2 u_pick (
        .pending (pending),
        .last    (last_ptr),
        .grant   (grant)
    );

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign last_ptr = PORT1;
`else
    port_id_t last_q, last_d;

    // Reset value PORT1 makes port 0 the winner of the first tie.
    always_comb begin
        last_d = last_q;
        if ((state_q == IDLE) && (|grant)) begin
            last_d = grant_to_id(grant);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_ptr = last_q;
`endif

    // A write that also carries a read strobe is treated purely as a write.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rd_d    = rd_q;
        port_d  = port_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d = ISSUE;
                    port_d  = grant_to_id(grant);
                    if (grant[1]) begin
                        addr_d  = bus.p1_addr;
                        wdata_d = bus.p1_wdata;
                        wstrb_d = bus.p1_wstrb;
                        rd_d    = bus.p1_rstrb & ~(|bus.p1_wstrb);
                    end else begin
                        addr_d  = bus.p0_addr;
                        wdata_d = bus.p0_wdata;
                        wstrb_d = bus.p0_wstrb;
                        rd_d    = bus.p0_rstrb & ~(|bus.p0_wstrb);
                    end
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rd_q    <= 1'b0;
            port_q  <= PORT0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rd_q    <= rd_d;
            port_q  <= port_d;
        end
    end

    // Grant is gated by reset so that every output reads zero while rst is low.
    assign bus.p0_gnt = rst & (state_q == IDLE) & grant[0];
    assign bus.p1_gnt = rst & (state_q == IDLE) & grant[1];

    assign bus.p0_done = (state_q == RESP) & (port_q == PORT0);
    assign bus.p1_done = (state_q == RESP) & (port_q == PORT1);
    assign bus.rdata   = ((state_q == RESP) && rd_q) ? bus.mem_rdata : '0;
    assign bus.busy    = (state_q != IDLE);

    assign bus.mem_addr  = (state_q == ISSUE) ? addr_q  : '0;
    assign bus.mem_wdata = (state_q == ISSUE) ? wdata_q : '0;
    assign bus.mem_wstrb = (state_q == ISSUE) ? wstrb_q : '0;
    assign bus.mem_rstrb = (state_q == ISSUE) & rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] envMem    [16];
    logic [31:0] shadowMem [16];

    // Memory the DUT actually talks to; read data is junk unless a read was strobed.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_wstrb[b]) envMem[bus.mem_addr[5:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
        if (bus.mem_rstrb) bus.mem_rdata <= envMem[bus.mem_addr[5:2]];
        else               bus.mem_rdata <= $urandom;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearReqs();
        bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_wstrb = '0; bus.p0_rstrb = 1'b0;
        bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_wstrb = '0; bus.p1_rstrb = 1'b0;
    endtask

    task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic rstrb);
        if (port == 0) begin
            bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_wstrb = wstrb; bus.p0_rstrb = rstrb;
        end else begin
            bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_wstrb = wstrb; bus.p1_rstrb = rstrb;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int pickPort(input bit r0, input bit r1, input int last);
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last == 0) ? 1 : 0;
`endif
    endfunction

    // Transaction-level model: a granted request shows on the memory one cycle later
    // and completes the cycle after that; no new grant while one is in flight.
    int          age = 0;
    int          lastGrant = 1;
    int          mPort = 0;
    logic [31:0] mAddr = '0;
    logic [31:0] mWdata = '0;
    logic [3:0]  mWstrb = '0;
    bit          mRead = 1'b0;

    always @(negedge clk) begin : compare
        logic [1:0]  eGnt;
        logic [1:0]  eDone;
        logic [31:0] eRdata, eAddr, eWdata;
        logic [3:0]  eWstrb;
        logic        eRstrb, eBusy;
        bit          r0, r1;
        int          win;
        eGnt = '0; eDone = '0; eRdata = '0; eAddr = '0; eWdata = '0;
        eWstrb = '0; eRstrb = 1'b0; eBusy = 1'b0;
        r0 = bus.p0_rstrb | (|bus.p0_wstrb);
        r1 = bus.p1_rstrb | (|bus.p1_wstrb);
        if (!rst) begin
            age = 0;
            lastGrant = 1;
        end else if (age == 0) begin
            win = pickPort(r0, r1, lastGrant);
            if (win >= 0) begin
                eGnt[win] = 1'b1;
                mPort  = win;
                mAddr  = (win == 0) ? bus.p0_addr  : bus.p1_addr;
                mWdata = (win == 0) ? bus.p0_wdata : bus.p1_wdata;
                mWstrb = (win == 0) ? bus.p0_wstrb : bus.p1_wstrb;
                mRead  = (mWstrb == 4'h0);
                lastGrant = win;
                age = 1;
            end
        end else if (age == 1) begin
            eBusy = 1'b1; eAddr = mAddr; eWdata = mWdata; eWstrb = mWstrb; eRstrb = mRead;
            for (int b = 0; b < 4; b++) begin
                if (mWstrb[b]) shadowMem[mAddr[5:2]][b*8 +: 8] = mWdata[b*8 +: 8];
            end
            age = 2;
        end else begin
            eBusy = 1'b1;
            eDone[mPort] = 1'b1;
            eRdata = mRead ? shadowMem[mAddr[5:2]] : 32'h0;
            age = 0;
        end
        checkOutput("m_p0_gnt",    32'(bus.p0_gnt),    32'(eGnt[0]));
        checkOutput("m_p1_gnt",    32'(bus.p1_gnt),    32'(eGnt[1]));
        checkOutput("m_p0_done",   32'(bus.p0_done),   32'(eDone[0]));
        checkOutput("m_p1_done",   32'(bus.p1_done),   32'(eDone[1]));
        checkOutput("m_rdata",     bus.rdata,          eRdata);
        checkOutput("m_busy",      32'(bus.busy),      32'(eBusy));
        checkOutput("m_mem_addr",  bus.mem_addr,       eAddr);
        checkOutput("m_mem_wdata", bus.mem_wdata,      eWdata);
        checkOutput("m_mem_wstrb", 32'(bus.mem_wstrb), 32'(eWstrb));
        checkOutput("m_mem_rstrb", 32'(bus.mem_rstrb), 32'(eRstrb));
    end

    initial begin
        int gotSeq [4];
        int expSeq [4];
        int nGot;
        int kind;

        for (int i = 0; i < 16; i++) envMem[i] = $urandom;
        envMem[4]  = 32'hDEADBEEF;
        envMem[8]  = 32'h11223344;
        envMem[13] = 32'hCAFEF00D;
        for (int i = 0; i < 16; i++) shadowMem[i] = envMem[i];
        bus.mem_rdata = '0;

        // Requests presented while held in reset must not be granted.
        clearReqs();
        applyStimulus(0, 32'h4, 32'h0, 4'h0, 1'b1);
        applyStimulus(1, 32'h8, 32'h1, 4'hF, 1'b0);
        @(negedge clk);
        checkOutput("rst_p0_gnt", 32'(bus.p0_gnt), 32'h0);
        checkOutput("rst_p1_gnt", 32'(bus.p1_gnt), 32'h0);
        checkOutput("rst_busy",   32'(bus.busy),   32'h0);
        nextCycle();
        clearReqs();
        rst = 1'b1;
        nextCycle();

        // Both ports continuously requesting.
`ifdef MEM_ARB_FIXED_PRIO_EN
        expSeq = '{0, 0, 0, 0};
`else
        expSeq = '{0, 1, 0, 1};
`endif
        gotSeq = '{-1, -1, -1, -1};
        nGot = 0;
        applyStimulus(0, 32'h10, 32'h0, 4'h0, 1'b1);
        applyStimulus(1, 32'h20, 32'h0, 4'h0, 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (nGot < 4 && bus.p0_gnt) begin gotSeq[nGot] = 0; nGot++; end
            if (nGot < 4 && bus.p1_gnt) begin gotSeq[nGot] = 1; nGot++; end
            nextCycle();
        end
        clearReqs();
        checkOutput("tie_grant_count", 32'(nGot), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("tie_grant%0d", i), 32'(gotSeq[i]), 32'(expSeq[i]));
        end
        nextCycle();

        // Port 0 read of 0x10.
        applyStimulus(0, 32'h10, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("rd_p0_gnt", 32'(bus.p0_gnt), 32'h1);
        nextCycle();
        clearReqs();
        @(negedge clk);
        checkOutput("rd_mem_rstrb", 32'(bus.mem_rstrb), 32'h1);
        checkOutput("rd_mem_addr",  bus.mem_addr,       32'h10);
        nextCycle();
        @(negedge clk);
        checkOutput("rd_p0_done", 32'(bus.p0_done), 32'h1);
        checkOutput("rd_rdata",   bus.rdata,        32'hDEADBEEF);
        nextCycle();

        // Port 1 partial write to 0x20, then read it back through port 0.
        applyStimulus(1, 32'h20, 32'hA5A5A5A5, 4'b0011, 1'b0);
        @(negedge clk);
        checkOutput("wr_p1_gnt", 32'(bus.p1_gnt), 32'h1);
        nextCycle();
        clearReqs();
        @(negedge clk);
        checkOutput("wr_mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
        checkOutput("wr_mem_rstrb", 32'(bus.mem_rstrb), 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("wr_p1_done", 32'(bus.p1_done), 32'h1);
        checkOutput("wr_rdata",   bus.rdata,        32'h0);
        nextCycle();
        applyStimulus(0, 32'h20, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("wr_strobe_dropped", 32'(bus.mem_wstrb), 32'h0);
        nextCycle();
        clearReqs();
        nextCycle();
        @(negedge clk);
        checkOutput("rb_rdata", bus.rdata, 32'h1122A5A5);
        nextCycle();

        // Read and write strobes together: the write wins.
        applyStimulus(0, 32'h30, 32'h0BADF00D, 4'hF, 1'b1);
        nextCycle();
        clearReqs();
        @(negedge clk);
        checkOutput("rw_mem_rstrb", 32'(bus.mem_rstrb), 32'h0);
        checkOutput("rw_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
        nextCycle();
        @(negedge clk);
        checkOutput("rw_rdata", bus.rdata, 32'h0);
        nextCycle();

        // Port 1 asks during port 0's RESP and must wait for the next IDLE.
        applyStimulus(0, 32'h04, 32'h0, 4'h0, 1'b1);
        nextCycle();
        clearReqs();
        nextCycle();
        applyStimulus(1, 32'h08, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        checkOutput("late_p0_done", 32'(bus.p0_done), 32'h1);
        checkOutput("late_p1_gnt_early", 32'(bus.p1_gnt), 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("late_p1_gnt", 32'(bus.p1_gnt), 32'h1);
        nextCycle();
        clearReqs();
        nextCycle();
        nextCycle();

        // Reset during the ISSUE cycle of a write abandons it.
        applyStimulus(0, 32'h34, 32'h12345678, 4'hF, 1'b0);
        nextCycle();
        clearReqs();
        rst = 1'b0;
        #1;
        checkOutput("arst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        checkOutput("arst_busy",      32'(bus.busy),      32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("arst_p0_done", 32'(bus.p0_done), 32'h0);
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("arst_idle_busy", 32'(bus.busy), 32'h0);
        nextCycle();
        applyStimulus(0, 32'h34, 32'h0, 4'h0, 1'b1);
        nextCycle();
        clearReqs();
        nextCycle();
        @(negedge clk);
        checkOutput("arst_no_write", bus.rdata, 32'hCAFEF00D);
        nextCycle();

        // Random traffic, checked by the model every cycle.
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < 2; p++) begin
                kind = int'($urandom_range(0, 3));
                applyStimulus(p, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                              (kind >= 2) ? 4'($urandom_range(1, 15)) : 4'h0,
                              (kind == 1) || (kind == 3));
            end
            nextCycle();
        end
        clearReqs();
        repeat (4) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
